// File: rtl/switch_debounce_led.sv
// switch_debounce_led
//   Front end between raw slide switches and board LEDs. Each switch bit is
//   synchronised into clk through two flops, then debounced. The debounced
//   level drives the LEDs directly (mode=0) or flips an LED bit on each press
//   (mode=1). One-cycle rise/fall pulses are produced per bit for downstream
//   logic.
//
// Ports
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous, active-high reset
//   mode    in   1      0 = led mirrors debounced switch, 1 = press toggles led
//   switch  in   WIDTH  raw asynchronous switch levels
//   led     out  WIDTH  registered LED drive
//   rise    out  WIDTH  1-cycle pulse: debounced level went 0->1
//   fall    out  WIDTH  1-cycle pulse: debounced level went 1->0
module switch_debounce_led #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the current mismatched cycle is the last one needed.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic [WIDTH-1:0]         led_q, led_d;

  // Per-bit debounce: a level differing from stable must persist for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the stable level
  // before then restarts the count, so short glitches never reach stable.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        rise_d[i]   = sync2_q[i];
        fall_d[i]   = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // LEDs follow the registered stable/rise values, so they lag stable by one
  // edge. Toggle mode works from the current LED value, which gives the
  // "keep value on 0->1 mode change" behaviour for free.
  always_comb begin
    led_d = mode ? (led_q ^ rise_q) : stable_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      led_q    <= '0;
    end else begin
      sync1_q  <= switch;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      led_q    <= led_d;
    end
  end

  assign led  = led_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_switch_debounce_led.sv
// Testbench for switch_debounce_led (WIDTH=6, DEBOUNCE_CYCLES=4).
// A window-based reference model predicts led/rise/fall every cycle; directed
// sequences add hand-computed literal expectations at key edges.
module tb_switch_debounce_led;

  localparam int W = 6;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         mode;
  logic [W-1:0] switch;
  logic [W-1:0] led, rise, fall;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  switch_debounce_led #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .switch (switch),
    .led    (led),
    .rise   (rise),
    .fall   (fall)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The switch value seen by the debouncer is the one sampled two edges
  // earlier. A bit's stable level flips when the last D synchronised samples
  // all disagree with it; the LED follows one edge behind.
  logic [W-1:0] s1_m, s2_m, st_m, led_m, rise_m, fall_m;
  logic [W-1:0] hist_m [D];   // hist_m[0] = newest earlier sample
  int           hcnt_m;

  function automatic logic [W-1:0] flip_mask(input logic [W-1:0] newest,
                                             input logic [W-1:0] st,
                                             input int           have);
    logic [W-1:0] m;
    m = '0;
    if (have >= D) begin
      for (int b = 0; b < W; b++) begin
        m[b] = (newest[b] != st[b]);
        for (int k = 0; k < D - 1; k++)
          if (hist_m[k][b] == st[b]) m[b] = 1'b0;
      end
    end
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_m   <= '0;
      s2_m   <= '0;
      st_m   <= '0;
      led_m  <= '0;
      rise_m <= '0;
      fall_m <= '0;
      hcnt_m <= 0;
      for (int k = 0; k < D; k++) hist_m[k] <= '0;
    end else begin
      led_m  <= mode ? (led_m ^ rise_m) : st_m;
      st_m   <= st_m ^ flip_mask(s2_m, st_m, hcnt_m + 1);
      rise_m <= flip_mask(s2_m, st_m, hcnt_m + 1) & ~st_m;
      fall_m <= flip_mask(s2_m, st_m, hcnt_m + 1) &  st_m;
      hist_m[0] <= s2_m;
      for (int k = 1; k < D; k++) hist_m[k] <= hist_m[k-1];
      hcnt_m <= (hcnt_m < D) ? hcnt_m + 1 : D;
      s2_m   <= s1_m;
      s1_m   <= switch;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_led",  led,  led_m);
      check("model_rise", rise, rise_m);
      check("model_fall", fall, fall_m);
      check("rise_fall_exclusive", rise & fall, '0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    mode   = 1'b0;
    switch = 6'h3F;

    // 1: reset and direct mirror
    ticks(2);
    chk_en = 1'b1;
    tick();
    check("rst_led",  led,  6'h00);
    check("rst_rise", rise, 6'h00);
    check("rst_fall", fall, 6'h00);
    rst = 1'b0;
    ticks(5);
    check("t1_rise_e5", rise, 6'h00);
    tick();
    check("t1_rise_e6", rise, 6'h3F);
    check("t1_led_e6",  led,  6'h00);
    tick();
    check("t1_rise_e7", rise, 6'h00);
    check("t1_led_e7",  led,  6'h3F);
    ticks(3);
    check("t1_led_hold", led, 6'h3F);

    // 2: glitch rejection
    switch = 6'h00;
    ticks(10);
    check("t2_pre_led", led, 6'h00);
    switch = 6'h01;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_rise", rise, 6'h00);
      check("t2_fall", fall, 6'h00);
      check("t2_led",  led,  6'h00);
    end
    switch = 6'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t2_rise", rise, 6'h00);
      check("t2_fall", fall, 6'h00);
      check("t2_led",  led,  6'h00);
    end

    // 3: toggle mode
    mode   = 1'b1;
    switch = 6'h04;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) begin
        check("t3a_rise", rise, 6'h04);
        check("t3a_led",  led,  6'h00);
      end
      if (k == 7) check("t3a_led_after", led, 6'h04);
    end
    switch = 6'h00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) check("t3b_fall", fall, 6'h04);
      check("t3b_led_kept", led, 6'h04);
    end
    switch = 6'h04;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) begin
        check("t3c_rise", rise, 6'h04);
        check("t3c_led",  led,  6'h04);
      end
      if (k == 7) check("t3c_led_after", led, 6'h00);
    end

    // 4: parallel bits
    mode   = 1'b0;
    switch = 6'h00;
    ticks(10);
    check("t4_pre_led", led, 6'h00);
    switch = 6'h05;
    ticks(5);
    check("t4_rise_e5", rise, 6'h00);
    tick();
    check("t4_rise_e6", rise, 6'h05);
    tick();
    check("t4_rise_e7", rise, 6'h00);
    check("t4_led_e7",  led,  6'h05);
    ticks(3);

    // 5: reset mid-count (toggle mode keeps led non-zero before the reset)
    mode   = 1'b1;
    switch = 6'h00;
    ticks(10);
    check("t5_pre_led", led, 6'h05);
    switch = 6'h3F;
    ticks(3);
    rst = 1'b1;
    #1;
    check("t5_rst_led",  led,  6'h00);
    check("t5_rst_rise", rise, 6'h00);
    check("t5_rst_fall", fall, 6'h00);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 6)  check("t5_no_early_rise", rise, 6'h00);
      if (k == 6) check("t5_rise_e6", rise, 6'h3F);
      if (k == 7) check("t5_led_e7",  led,  6'h3F);
    end

    // 6: mode switch with led=04, stable=01
    mode   = 1'b0;
    switch = 6'h00;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    ticks(3);
    switch = 6'h05;
    ticks(10);
    check("t6_mirror", led, 6'h05);
    mode   = 1'b1;
    switch = 6'h04;
    ticks(10);
    check("t6_release0", led, 6'h05);
    switch = 6'h05;
    ticks(10);
    check("t6_repress0", led, 6'h04);
    switch = 6'h01;
    ticks(10);
    check("t6_release2", led, 6'h04);
    mode = 1'b0;
    tick();
    check("t6_led",  led,  6'h01);
    check("t6_rise", rise, 6'h00);
    check("t6_fall", fall, 6'h00);
    ticks(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
